program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//  Byte-stream boot loader sitting directly upstream of cpu. Accepts framed bytes over a
//  valid/ready link, assembles 32-bit words and writes them into instruction memory
//  (addr_ext/wen_ext/wdata_ext) or data memory (addr_ext_2/wen_ext_2/wdata_ext_2).
//  On a RUN command it drives cpu.enable high; on HALT it drops it again.
// PARAMETERS
//  IMEM_WORDS  512   instruction-memory capacity in words; larger counts are errors
//  DMEM_WORDS  1024  data-memory capacity in words; larger counts are errors
// PORTS
//  clk          in   1   clock, all state updates on rising edge
//  arst         in   1   asynchronous active-high reset
//  in_valid     in   1   input byte valid
//  in_data      in   8   input byte
//  in_ready     out  1   loader can accept a byte this cycle
//  addr_ext     out  32  IMEM write byte address (word_index<<2)
//  wen_ext      out  1   IMEM write strobe, one cycle per word
//  wdata_ext    out  32  IMEM write word
//  addr_ext_2   out  32  DMEM write byte address (word_index<<2)
//  wen_ext_2    out  1   DMEM write strobe, one cycle per word
//  wdata_ext_2  out  32  DMEM write word
//  cpu_enable   out  1   drives cpu.enable
//  busy         out  1   high in any state except IDLE and RUN
//  error        out  1   sticky frame error
// BEHAVIOUR
//  - Reset: all outputs 0 except in_ready=1; state IDLE; word index, byte count cleared.
//  - Byte transfer occurs on a cycle with in_valid && in_ready. in_ready=1 in IDLE, CNT_HI,
//    CNT_LO, DATA, CSUM, RUN; 0 in WRITE and ERR.
//  - Frame: CMD byte, then for LOAD: count[15:8], count[7:0], count*4 data bytes MSB-first.
//    CMD 0x01 LOAD_IMEM, 0x02 LOAD_DMEM, 0x03 RUN, 0x04 HALT.
//  - IDLE: 0x01/0x02 -> CNT_HI (target latched); 0x03 -> RUN; 0x04 -> IDLE (no-op);
//    any other byte -> ERR.
//  - CNT_HI -> CNT_LO -> DATA. count==0 -> skip DATA (go to CSUM if enabled, else IDLE).
//    count > IMEM_WORDS/DMEM_WORDS for the target -> ERR on the CNT_LO accept.
//  - DATA: shift byte into 32-bit assembly register (first byte -> [31:24]); on 4th byte
//    -> WRITE. WRITE lasts exactly one cycle: wen of target =1, addr=word_index<<2,
//    wdata=assembled word; non-target wen stays 0. Word index increments; if index==count
//    -> CSUM/IDLE else DATA. Word index restarts at 0 on every LOAD frame.
//  - addr/wdata outputs hold last written value when wen=0.
//  - RUN: cpu_enable=1 registered (asserts cycle after RUN byte accepted). Bytes accepted
//    and ignored except 0x04 -> IDLE, cpu_enable=0 next cycle. No loads possible in RUN.
//  - ERR: sticky until arst; error=1, cpu_enable=0, no writes.
//  - arst mid-frame: immediate return to reset values; partial word discarded, never written.
// CONFIGURATION
//  LOADER_CHECKSUM_EN defined: after last data word (or count==0), state CSUM takes one
//   byte; it must equal XOR of all data bytes of the frame; match -> IDLE, mismatch -> ERR.
//   XOR accumulator clears on CMD accept.
//  Not defined: no CSUM state; frame ends after last WRITE, returns to IDLE.
// TESTING
//  1. Reset: assert arst mid-cycle -> all outputs 0, in_ready=1 immediately, no clk needed.
//  2. Send 01 00 02 20 01 00 0A 8C 02 00 04 -> wen_ext pulses twice: addr 0 data 0x2001000A,
//     addr 4 data 0x8C020004; wen_ext_2 never high; busy low after second write.
//  3. Send 02 00 01 DE AD BE EF -> one wen_ext_2 pulse, addr_ext_2=0, wdata_ext_2=0xDEADBEEF.
//  4. Send 03 then 55 then 04 -> cpu_enable 1 cycle after 03, stays 1 through 55, 0 after 04.
//  5. Send 01 02 01 (count 513) -> error=1, in_ready=0, later bytes and RUN ignored.
//  6. With LOADER_CHECKSUM_EN: 02 00 01 11 22 33 44 44 -> OK; last byte 45 -> error=1.
//  Also: in_valid toggled randomly -> identical writes; arst after 2 data bytes -> no write.

Source files
------------

// File: rtl/program_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader_if
//  Purpose  : Byte-link and memory-write bus bundle for program_loader.
//             master = byte source / memory side, slave = the loader itself.
//  Revision : 1.0  initial release
// ============================================================================
interface program_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] addr_ext;
  logic        wen_ext;
  logic [31:0] wdata_ext;
  logic [31:0] addr_ext_2;
  logic        wen_ext_2;
  logic [31:0] wdata_ext_2;

  modport master (
    output in_valid, in_data,
    input  in_ready, addr_ext, wen_ext, wdata_ext, addr_ext_2, wen_ext_2, wdata_ext_2
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, addr_ext, wen_ext, wdata_ext, addr_ext_2, wen_ext_2, wdata_ext_2
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
//  Module   : program_loader
//  Purpose  : Framed byte-stream boot loader. Assembles 32-bit words and writes
//             them to IMEM or DMEM; RUN/HALT commands gate cpu_enable.
//  Options  : LOADER_CHECKSUM_EN - adds a trailing XOR checksum byte per LOAD.
//  Revision : 1.0  initial release
// ============================================================================
module program_loader #(
  parameter int IMEM_WORDS = 512,
  parameter int DMEM_WORDS = 1024
) (
  input  logic             clk,
  input  logic             arst,
  program_loader_if.slave  bus,
  output logic             cpu_enable,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CNT_HI = 3'd1,
    S_CNT_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_RUN    = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [16:0] C_IMEM_LIMIT = 17'(IMEM_WORDS);
  localparam logic [16:0] C_DMEM_LIMIT = 17'(DMEM_WORDS);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t C_FRAME_END = S_CSUM;
`else
  localparam state_t C_FRAME_END = S_IDLE;
`endif

  state_t      r_state, w_next;
  logic        r_tgt_dmem;
  logic [7:0]  r_cnt_hi;
  logic [15:0] r_count;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_asm;
  logic [31:0] r_addr_i, r_wdata_i, r_addr_d, r_wdata_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  logic        w_accept;
  logic [15:0] w_count_full;
  logic        w_over;
  logic        w_last_word;

  assign w_accept     = bus.in_valid && bus.in_ready;
  assign w_count_full = {r_cnt_hi, bus.in_data};
  assign w_over       = {1'b0, w_count_full} > (r_tgt_dmem ? C_DMEM_LIMIT : C_IMEM_LIMIT);
  assign w_last_word  = (r_word_idx + 16'd1) == r_count;

  // State register
  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state decode and state-derived outputs
  always_comb begin
    w_next          = r_state;
    bus.in_ready    = 1'b1;
    bus.wen_ext     = 1'b0;
    bus.wen_ext_2   = 1'b0;
    cpu_enable      = 1'b0;
    busy            = 1'b1;
    error           = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) begin
          case (bus.in_data)
            8'h01, 8'h02: w_next = S_CNT_HI;
            8'h03:        w_next = S_RUN;
            8'h04:        w_next = S_IDLE;
            default:      w_next = S_ERR;
          endcase
        end
      end
      S_CNT_HI: if (w_accept) w_next = S_CNT_LO;
      S_CNT_LO: begin
        if (w_accept) begin
          if (w_over)                    w_next = S_ERR;
          else if (w_count_full == 16'd0) w_next = C_FRAME_END;
          else                           w_next = S_DATA;
        end
      end
      S_DATA: if (w_accept && r_byte_cnt == 2'd3) w_next = S_WRITE;
      S_WRITE: begin
        bus.in_ready  = 1'b0;
        bus.wen_ext   = !r_tgt_dmem;
        bus.wen_ext_2 = r_tgt_dmem;
        w_next        = w_last_word ? C_FRAME_END : S_DATA;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: if (w_accept) w_next = (bus.in_data == r_xor) ? S_IDLE : S_ERR;
`endif
      S_RUN: begin
        busy       = 1'b0;
        cpu_enable = 1'b1;
        if (w_accept && bus.in_data == 8'h04) w_next = S_IDLE;
      end
      S_ERR: begin
        bus.in_ready = 1'b0;
        error        = 1'b1;
        w_next       = S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Frame datapath: target/count capture, word assembly, write-port registers
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_tgt_dmem <= 1'b0;
      r_cnt_hi   <= 8'd0;
      r_count    <= 16'd0;
      r_word_idx <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_asm      <= 24'd0;
      r_addr_i   <= 32'd0;
      r_wdata_i  <= 32'd0;
      r_addr_d   <= 32'd0;
      r_wdata_d  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      r_xor      <= 8'd0;
`endif
    end else if (r_state == S_WRITE) begin
      r_word_idx <= r_word_idx + 16'd1;
    end else if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_data == 8'h01 || bus.in_data == 8'h02) begin
            r_tgt_dmem <= (bus.in_data == 8'h02);
            r_word_idx <= 16'd0;
            r_byte_cnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
          end
        end
        S_CNT_HI: r_cnt_hi <= bus.in_data;
        S_CNT_LO: r_count  <= w_count_full;
        S_DATA: begin
          r_asm      <= {r_asm[15:0], bus.in_data};
          r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          r_xor      <= r_xor ^ bus.in_data;
`endif
          // Address/data registers load as the word completes so they are
          // valid during the WRITE strobe and hold afterwards.
          if (r_byte_cnt == 2'd3) begin
            if (r_tgt_dmem) begin
              r_addr_d  <= {14'd0, r_word_idx, 2'b00};
              r_wdata_d <= {r_asm, bus.in_data};
            end else begin
              r_addr_i  <= {14'd0, r_word_idx, 2'b00};
              r_wdata_i <= {r_asm, bus.in_data};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.addr_ext    = r_addr_i;
  assign bus.wdata_ext   = r_wdata_i;
  assign bus.addr_ext_2  = r_addr_d;
  assign bus.wdata_ext_2 = r_wdata_d;

endmodule
`default_nettype wire
